mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised memory-access pipeline stage sitting between the execute stage (es) and write-back stage (ws) of the in-order MIPS core. Generalises the single-cycle memory stage: it waits for a variable-latency data-SRAM response, aligns and sign/zero-extends sub-word loads, buffers a response that arrives while ws is stalled, and drops the response of a flushed load. Presents destination-register information to decode for hazard detection.

## Interface
- XLEN, 32: datapath width; only 32 is legal this generation.
- RF_AW, 5: register-file address width.
- ES_TO_MS_BUS_WD, 2*XLEN+RF_AW+5: es bus width, layout {pc, load_op, ld_type[2:0], rf_we, rf_waddr, alu_result}.
- MS_TO_WS_BUS_WD, 2*XLEN+RF_AW+1: ws bus width, layout {pc, rf_we, rf_waddr, rf_wdata}.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  in  1  ws can accept this cycle.
- ms_allowin  out  1  stage can accept from es.
- es_to_ms_valid  in  1  es bus valid.
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  execute results.
- flush  in  1  exception/ERET cancel of the in-stage instruction.
- cpu_data_data_ok  in  1  one-cycle pulse: load response valid.
- cpu_data_rdata  in  XLEN  load response data, valid with data_ok.
- ms_to_ws_valid  out  1  ws bus valid.
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  write-back payload.
- ms_valid  out  1  stage holds a live instruction.
- ms_rf_waddr  out  RF_AW  destination register (qualified by ms_valid & rf_we).
- ms_rf_wdata  out  XLEN  forwarding data (present only with MS_FWD_EN).
- ms_fwd_ok  out  1  ms_rf_wdata is final (present only with MS_FWD_EN).

## Operation
- Payload register loads es_to_ms_bus when ms_allowin & es_to_ms_valid; held otherwise.
- ms_valid: next = es_to_ms_valid when ms_allowin; cleared by flush (flush priority over load-in except when ms_allowin, then new instruction is accepted).
- ms_ready_go = ~load_op | data_ok_now | rbuf_vld, where data_ok_now = cpu_data_data_ok & ~drop_cnt_nonzero.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go & ~flush.
- Response buffer: if data_ok_now and ~ws_allowin with a valid load in stage, capture rdata into rbuf, set rbuf_vld; rbuf_vld clears when the stage hands off to ws or on flush. Raw data selected = rbuf_vld ? rbuf : cpu_data_rdata.
- Drop counter (2 bits): flush of a valid load still awaiting response increments; each cpu_data_data_ok while nonzero decrements and is consumed, never seen by the live instruction. Saturates at 3 (upstream guarantees at most 1 outstanding).
- Load alignment by a = alu_result[1:0]: ld_type 0 LW (word, a ignored); 1 LB, 2 LBU (byte at a*8, sign/zero extend to XLEN); 3 LH, 4 LHU (half at a[1]*16, sign/zero extend); 5–7 treated as LW. Misalignment is trapped upstream; not checked here.
- rf_wdata = load_op ? aligned load data : alu_result.

## Timing
- Reset: ms_valid=0, rbuf_vld=0, drop counter=0, payload=0; hence ms_allowin=1, ms_to_ws_valid=0, ms_fwd_ok=0.
- Non-load: 1 cycle in stage, handoff same cycle if ws_allowin.
- Load: handoff in the cycle data_ok_now arrives (combinational rdata path) or any later cycle from rbuf.
- data_ok and flush same cycle: response discarded, no counter increment.
- Flush with ms_allowin and es_to_ms_valid same cycle: new instruction accepted valid.

## Configuration
- MS_FWD_EN defined: ms_rf_wdata = rf_wdata, ms_fwd_ok = ms_valid & ms_ready_go; decode may bypass.
- Undefined: both ports and logic absent; decode stalls on any ms_valid & rf_we address match.

## Structure
- Shared package/header cpu.vh: bus width macros, field layouts, LD_* type encodings.
- One sub-module: ms_load_align (combinational extractor: raw data, a, ld_type -> aligned data).
- Flops via sirv_gnrl_dfflr.

## Test plan
- ALU op, alu_result=0x1234, ws_allowin=1 -> ms_to_ws_bus rf_wdata=0x1234 next cycle after capture, ms_allowin stays 1.
- LB a=3, rdata=0x80FF_0000 after 2-cycle wait -> rf_wdata=0xFFFF_FF80; ms_allowin=0 during wait.
- LHU a=2, rdata=0x8001_1234 -> 0x0000_8001; LH same -> 0xFFFF_8001.
- LW, data_ok with ws_allowin=0 for 3 cycles, rdata changes afterward -> handoff carries buffered original word.
- Load flushed before response, then new LW; first data_ok (0xDEAD) dropped, second (0xBEEF) -> rf_wdata=0xBEEF.
- Reset asserted mid-wait -> next cycle ms_valid=0, ms_allowin=1, stale data_ok ignored by no-load stage.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-access stage: bus layouts and load-type encodings.
package mem_stage_lsu_pkg;

  localparam int unsigned LSU_XLEN  = 32;
  localparam int unsigned LSU_RF_AW = 5;

  // ld_type encodings; 5..7 behave as LW
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef struct packed {
    logic [LSU_XLEN-1:0]  pc;
    logic                 load_op;
    logic [2:0]           ld_type;
    logic                 rf_we;
    logic [LSU_RF_AW-1:0] rf_waddr;
    logic [LSU_XLEN-1:0]  alu_result;
  } es_to_ms_t;

  typedef struct packed {
    logic [LSU_XLEN-1:0]  pc;
    logic                 rf_we;
    logic [LSU_RF_AW-1:0] rf_waddr;
    logic [LSU_XLEN-1:0]  rf_wdata;
  } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Sub-word load extractor: picks byte/half by address and sign/zero extends.
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [LSU_XLEN-1:0] raw,
  input  logic [1:0]          addr,
  input  logic [2:0]          ld_type,
  output logic [LSU_XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection by low address bits
  always_comb begin
    byte_sel = raw[7:0];
    case (addr)
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      2'd3:    byte_sel = raw[31:24];
      default: byte_sel = raw[7:0];
    endcase
    half_sel = addr[1] ? raw[31:16] : raw[15:0];
  end

  // Extension by load type
  always_comb begin
    data = raw;
    case (ld_type)
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'd0, byte_sel};
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'd0, half_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage between execute and write-back.
// Waits for the data-SRAM response, aligns sub-word loads, buffers a response
// that arrives while write-back is stalled and drops responses of flushed loads.
// Optional macro MS_FWD_EN adds the ms_rf_wdata / ms_fwd_ok forwarding ports.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned XLEN            = LSU_XLEN,
  parameter int unsigned RF_AW           = LSU_RF_AW,
  parameter int unsigned ES_TO_MS_BUS_WD = 2*XLEN + RF_AW + 5,
  parameter int unsigned MS_TO_WS_BUS_WD = 2*XLEN + RF_AW + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       flush,
  input  logic                       cpu_data_data_ok,
  input  logic [XLEN-1:0]            cpu_data_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_valid,
  output logic [RF_AW-1:0]           ms_rf_waddr
`ifdef MS_FWD_EN
  ,
  output logic [XLEN-1:0]            ms_rf_wdata,
  output logic                       ms_fwd_ok
`endif
);

  es_to_ms_t       es_in;
  es_to_ms_t       ms_pl;
  ms_to_ws_t       ws_out;
  logic [XLEN-1:0] rbuf;
  logic            rbuf_vld;
  logic [1:0]      drop_cnt;
  logic            data_ok_now;
  logic            ms_ready_go;
  logic            handoff;
  logic            rbuf_set;
  logic            drop_inc;
  logic            drop_dec;
  logic [XLEN-1:0] raw_data;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] rf_wdata;

  assign es_in = es_to_ms_bus;

  // Handshake and response qualification
  always_comb begin
    data_ok_now    = cpu_data_data_ok & (drop_cnt == 2'd0);
    ms_ready_go    = ~ms_pl.load_op | data_ok_now | rbuf_vld;
    ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    ms_to_ws_valid = ms_valid & ms_ready_go & ~flush;
    handoff        = ms_to_ws_valid & ws_allowin;
    rbuf_set       = ms_valid & ms_pl.load_op & data_ok_now & ~ws_allowin & ~flush;
    drop_inc       = flush & ms_valid & ms_pl.load_op & ~rbuf_vld & ~data_ok_now;
    drop_dec       = cpu_data_data_ok & (drop_cnt != 2'd0);
  end

  // Stage valid bit: new instruction wins over flush when the stage accepts
  always_ff @(posedge clk) begin
    if (reset)           ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
    else if (flush)      ms_valid <= 1'b0;
  end

  // Instruction payload from execute
  always_ff @(posedge clk) begin
    if (reset)                            ms_pl <= '0;
    else if (ms_allowin && es_to_ms_valid) ms_pl <= es_in;
  end

  // Response buffer for data returned while write-back is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      rbuf_vld <= 1'b0;
      rbuf     <= '0;
    end else if (flush || handoff) begin
      rbuf_vld <= 1'b0;
    end else if (rbuf_set) begin
      rbuf_vld <= 1'b1;
      rbuf     <= cpu_data_rdata;
    end
  end

  // Count of responses still owed to flushed loads
  always_ff @(posedge clk) begin
    if (reset)                                        drop_cnt <= 2'd0;
    else if (drop_inc && !drop_dec && drop_cnt != 2'd3) drop_cnt <= drop_cnt + 2'd1;
    else if (drop_dec && !drop_inc)                   drop_cnt <= drop_cnt - 2'd1;
  end

  assign raw_data = rbuf_vld ? rbuf : cpu_data_rdata;

  mem_stage_lsu_load_align u_load_align (
    .raw     (raw_data),
    .addr    (ms_pl.alu_result[1:0]),
    .ld_type (ms_pl.ld_type),
    .data    (load_data)
  );

  // Write-back payload assembly
  always_comb begin
    rf_wdata        = ms_pl.load_op ? load_data : ms_pl.alu_result;
    ws_out.pc       = ms_pl.pc;
    ws_out.rf_we    = ms_pl.rf_we;
    ws_out.rf_waddr = ms_pl.rf_waddr;
    ws_out.rf_wdata = rf_wdata;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_rf_waddr  = ms_pl.rf_waddr;

`ifdef MS_FWD_EN
  assign ms_rf_wdata = rf_wdata;
  assign ms_fwd_ok   = ms_valid & ms_ready_go;
`endif

endmodule
